accel_buffer_ctrl: RTL and testbench

// - Parametrised buffer controller between the AHB slave and the systolic array.
// - Holds three FIFOs: weight (DEPTH words), input (DEPTH words) and output (OUT_DEPTH words).
// - A single FSM streams weights, then inputs, into the array, and collects activations for AHB readback.
// - Adds occupancy count outputs, a weights-loaded interlock and an optional auto-start mode.
//

---
 rtl/accel_buffer_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_accel_buffer_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : accel_buffer_ctrl                                           |
// | Weight/input/output FIFOs plus a phase FSM that streams weights,     |
// | then inputs, into the systolic array and collects activations.       |
// | Option : ACCEL_BUF_AUTO_START_EN - inference starts without request. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module accel_buffer_ctrl #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 8,
  parameter int OUT_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           write_weight,
  input  logic [DATA_W-1:0]              weight_data,
  input  logic                           write_input,
  input  logic [DATA_W-1:0]              input_data,
  input  logic                           load_weight,
  input  logic                           start_inference,
  input  logic                           output_read,
  input  logic                           array_busy,
  input  logic [DATA_W-1:0]              activations,
  input  logic                           activations_valid,
  output logic [DATA_W-1:0]              output_data,
  output logic                           data_ready,
  output logic                           design_busy,
  output logic                           occupancy_err_w,
  output logic                           occupancy_err_i,
  output logic                           occupancy_err_o,
  output logic                           device_busy_err,
  output logic                           load,
  output logic                           array_start,
  output logic [DATA_W-1:0]              inputs,
  output logic [$clog2(DEPTH+1)-1:0]     w_count,
  output logic [$clog2(DEPTH+1)-1:0]     i_count,
  output logic [$clog2(OUT_DEPTH+1)-1:0] o_count
);
  localparam int c_cnt_w  = $clog2(DEPTH + 1);
  localparam int c_ocnt_w = $clog2(OUT_DEPTH + 1);
  localparam int c_ptr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_optr_w = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [c_cnt_w-1:0]  c_full   = c_cnt_w'(DEPTH);
  localparam logic [c_ocnt_w-1:0] c_ofull  = c_ocnt_w'(OUT_DEPTH);
  localparam logic [c_ptr_w-1:0]  c_last   = c_ptr_w'(DEPTH - 1);
  localparam logic [c_optr_w-1:0] c_olast  = c_optr_w'(OUT_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_INFER, S_COLLECT} state_t;

  state_t                r_state;
  logic [c_ptr_w-1:0]    r_phase;
  logic                  r_weights_loaded;
  logic [DATA_W-1:0]     r_w_mem [DEPTH];
  logic [DATA_W-1:0]     r_i_mem [DEPTH];
  logic [DATA_W-1:0]     r_o_mem [OUT_DEPTH];
  logic [c_ptr_w-1:0]    r_w_wr, r_w_rd, r_i_wr, r_i_rd;
  logic [c_optr_w-1:0]   r_o_wr, r_o_rd;

  logic w_idle, w_w_push, w_i_push, w_w_pop, w_i_pop, w_o_push, w_o_pop;
  logic w_load_ok, w_start_ok, w_start_req, w_go_load, w_go_start, w_req_err;

  function automatic logic [c_ptr_w-1:0] f_wrap(input logic [c_ptr_w-1:0] p);
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [c_optr_w-1:0] f_owrap(input logic [c_optr_w-1:0] p);
    return (p == c_olast) ? '0 : p + 1'b1;
  endfunction

  // Requests and pushes are judged on pre-edge counts only.
  assign w_idle     = (r_state == S_IDLE);
  assign w_w_push   = write_weight && (w_count < c_full) && (r_state != S_LOAD_W);
  assign w_i_push   = write_input && (i_count < c_full) && (r_state != S_INFER);
  assign w_load_ok  = w_idle && (w_count == c_full) && !array_busy;
  assign w_start_ok = w_idle && (i_count == c_full) && r_weights_loaded &&
                      (o_count == '0) && !array_busy;
`ifdef ACCEL_BUF_AUTO_START_EN
  assign w_start_req = 1'b1;
`else
  assign w_start_req = start_inference;
`endif
  assign w_go_load  = load_weight && w_load_ok;
  assign w_go_start = w_start_req && w_start_ok && !w_go_load;
  assign w_req_err  = (load_weight && !w_go_load) || (start_inference && !w_go_start);
  assign w_w_pop    = w_go_load || ((r_state == S_LOAD_W) && (r_phase != c_last));
  assign w_i_pop    = w_go_start || ((r_state == S_INFER) && (r_phase != c_last));
  assign w_o_push   = activations_valid && (o_count < c_ofull);
  assign w_o_pop    = output_read && (o_count != '0);

  assign design_busy = !w_idle;
  assign data_ready  = w_idle && (o_count != '0);

  always_ff @(posedge clk) begin
    if (w_w_push) r_w_mem[r_w_wr] <= weight_data;
    if (w_i_push) r_i_mem[r_i_wr] <= input_data;
    if (w_o_push) r_o_mem[r_o_wr] <= activations;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_w_wr <= '0; r_w_rd <= '0; w_count <= '0;
      r_i_wr <= '0; r_i_rd <= '0; i_count <= '0;
      r_o_wr <= '0; r_o_rd <= '0; o_count <= '0;
      output_data     <= '0;
      occupancy_err_w <= 1'b0;
      occupancy_err_i <= 1'b0;
      occupancy_err_o <= 1'b0;
    end else begin
      if (w_w_push) r_w_wr <= f_wrap(r_w_wr);
      if (w_w_pop)  r_w_rd <= f_wrap(r_w_rd);
      w_count <= w_count + c_cnt_w'(w_w_push) - c_cnt_w'(w_w_pop);
      if (w_i_push) r_i_wr <= f_wrap(r_i_wr);
      if (w_i_pop)  r_i_rd <= f_wrap(r_i_rd);
      i_count <= i_count + c_cnt_w'(w_i_push) - c_cnt_w'(w_i_pop);
      if (w_o_push) r_o_wr <= f_owrap(r_o_wr);
      if (w_o_pop) begin
        r_o_rd      <= f_owrap(r_o_rd);
        output_data <= r_o_mem[r_o_rd];
      end
      o_count <= o_count + c_ocnt_w'(w_o_push) - c_ocnt_w'(w_o_pop);
      occupancy_err_w <= write_weight && !w_w_push;
      occupancy_err_i <= write_input && !w_i_push;
      occupancy_err_o <= (activations_valid && !w_o_push) || (output_read && !w_o_pop);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state          <= S_IDLE;
      r_phase          <= '0;
      r_weights_loaded <= 1'b0;
      load             <= 1'b0;
      array_start      <= 1'b0;
      inputs           <= '0;
      device_busy_err  <= 1'b0;
    end else begin
      device_busy_err <= w_req_err;
      case (r_state)
        S_IDLE: begin
          r_phase <= '0;
          if (w_go_load) begin
            r_state <= S_LOAD_W;
            load    <= 1'b1;
            inputs  <= r_w_mem[r_w_rd];
          end else if (w_go_start) begin
            r_state     <= S_INFER;
            array_start <= 1'b1;
            inputs      <= r_i_mem[r_i_rd];
          end
        end
        S_LOAD_W: begin
          if (r_phase == c_last) begin
            r_state          <= S_IDLE;
            load             <= 1'b0;
            inputs           <= '0;
            r_weights_loaded <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
            inputs  <= r_w_mem[r_w_rd];
          end
        end
        S_INFER: begin
          if (r_phase == c_last) begin
            r_state     <= S_COLLECT;
            array_start <= 1'b0;
            inputs      <= '0;
          end else begin
            r_phase <= r_phase + 1'b1;
            inputs  <= r_i_mem[r_i_rd];
          end
        end
        default: begin
          if (o_count == c_ofull) r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_accel_buffer_ctrl.sv
`default_nettype none
// Bench for accel_buffer_ctrl: vector table, directed phase sequences and a
// randomized run against a queue-based reference model.
module tb_accel_buffer_ctrl;
  localparam int DATA_W = 64;
  localparam int DEPTH = 8;
  localparam int OUT_DEPTH = 8;
`ifdef ACCEL_BUF_AUTO_START_EN
  localparam bit c_auto = 1'b1;
`else
  localparam bit c_auto = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic write_weight = 0, write_input = 0, load_weight = 0, start_inference = 0;
  logic output_read = 0, array_busy = 0, activations_valid = 0;
  logic [DATA_W-1:0] weight_data = '0, input_data = '0, activations = '0;
  logic [DATA_W-1:0] output_data, inputs;
  logic data_ready, design_busy, occupancy_err_w, occupancy_err_i, occupancy_err_o;
  logic device_busy_err, load, array_start;
  logic [3:0] w_count, i_count, o_count;

  int n_tests = 0;
  int n_fail = 0;

  accel_buffer_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .n_rst(n_rst),
    .write_weight(write_weight), .weight_data(weight_data),
    .write_input(write_input), .input_data(input_data),
    .load_weight(load_weight), .start_inference(start_inference),
    .output_read(output_read), .array_busy(array_busy),
    .activations(activations), .activations_valid(activations_valid),
    .output_data(output_data), .data_ready(data_ready), .design_busy(design_busy),
    .occupancy_err_w(occupancy_err_w), .occupancy_err_i(occupancy_err_i),
    .occupancy_err_o(occupancy_err_o), .device_busy_err(device_busy_err),
    .load(load), .array_start(array_start), .inputs(inputs),
    .w_count(w_count), .i_count(i_count), .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    write_weight = 0; write_input = 0; load_weight = 0; start_inference = 0;
    output_read = 0; array_busy = 0; activations_valid = 0;
    weight_data = '0; input_data = '0; activations = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic push_inputs(input logic [63:0] base);
    for (int k = 0; k < DEPTH; k++) begin
      write_input = 1; input_data = base + 64'(k);
      tick();
    end
    write_input = 0;
  endtask

  // ---------------- reference model ----------------
  logic [63:0] wq[$], iq[$], oq[$], sq[$];
  int  m_kind;          // 0 none, 1 weights streaming, 2 inputs streaming
  bit  m_collect, m_wl;
  bit  e_load, e_start, e_ew, e_ei, e_eo, e_be;
  logic [63:0] e_inputs, e_out;

  function automatic int m_wc();
    return wq.size() + ((m_kind == 1) ? sq.size() : 0);
  endfunction
  function automatic int m_ic();
    return iq.size() + ((m_kind == 2) ? sq.size() : 0);
  endfunction

  task automatic model_reset();
    wq.delete(); iq.delete(); oq.delete(); sq.delete();
    m_kind = 0; m_collect = 0; m_wl = 0;
    e_load = 0; e_start = 0; e_ew = 0; e_ei = 0; e_eo = 0; e_be = 0;
    e_inputs = '0; e_out = '0;
  endtask

  task automatic model_step();
    int wc, ic, oc;
    bit idle, wp, ip, go_l, go_s, op, rp;
    wc = m_wc(); ic = m_ic(); oc = oq.size();
    idle = (m_kind == 0) && !m_collect;
    wp = write_weight && wc < DEPTH && m_kind != 1;
    ip = write_input && ic < DEPTH && m_kind != 2;
    go_l = load_weight && idle && wc == DEPTH && !array_busy;
    go_s = (start_inference || c_auto) && idle && ic == DEPTH && m_wl && oc == 0
           && !array_busy && !go_l;
    e_be = (load_weight && !go_l) || (start_inference && !go_s);
    e_ew = write_weight && !wp;
    e_ei = write_input && !ip;
    op = activations_valid && oc < OUT_DEPTH;
    rp = output_read && oc > 0;
    e_eo = (activations_valid && !op) || (output_read && !rp);
    if (rp) e_out = oq.pop_front();
    if (op) oq.push_back(activations);
    if (m_kind != 0) begin
      if (sq.size() > 0) e_inputs = sq.pop_front();
      else begin
        if (m_kind == 1) m_wl = 1; else m_collect = 1;
        m_kind = 0; e_load = 0; e_start = 0; e_inputs = '0;
      end
    end else if (m_collect) begin
      if (oc == OUT_DEPTH) m_collect = 0;
    end else if (go_l) begin
      sq = wq; wq.delete(); m_kind = 1; e_load = 1; e_inputs = sq.pop_front();
    end else if (go_s) begin
      sq = iq; iq.delete(); m_kind = 2; e_start = 1; e_inputs = sq.pop_front();
    end
    if (wp) wq.push_back(weight_data);
    if (ip) iq.push_back(input_data);
  endtask

  task automatic model_compare();
    bit busy;
    busy = (m_kind != 0) || m_collect;
    chk("rnd_w_count", 64'(w_count), 64'(m_wc()));
    chk("rnd_i_count", 64'(i_count), 64'(m_ic()));
    chk("rnd_o_count", 64'(o_count), 64'(oq.size()));
    chk("rnd_load", 64'(load), 64'(e_load));
    chk("rnd_array_start", 64'(array_start), 64'(e_start));
    chk("rnd_inputs", inputs, e_inputs);
    chk("rnd_output_data", output_data, e_out);
    chk("rnd_err_w", 64'(occupancy_err_w), 64'(e_ew));
    chk("rnd_err_i", 64'(occupancy_err_i), 64'(e_ei));
    chk("rnd_err_o", 64'(occupancy_err_o), 64'(e_eo));
    chk("rnd_busy_err", 64'(device_busy_err), 64'(e_be));
    chk("rnd_design_busy", 64'(design_busy), 64'(busy));
    chk("rnd_data_ready", 64'(data_ready), 64'(oq.size() > 0 && !busy));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit ww, wi, lw, si, rd, av;
    logic [63:0] d;
    int ew, ei, eo;
    bit eerr_w, eerr_i, eerr_o, ebusy_err, edr;
    logic [63:0] eout;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{0,0,0,0,0,0, 64'h0,  0,0,0, 0,0,0,0,0, 64'h0};
    vecs[1]  = '{0,0,0,1,0,0, 64'h0,  0,0,0, 0,0,0,1,0, 64'h0};
    vecs[2]  = '{0,0,0,0,1,0, 64'h0,  0,0,0, 0,0,1,0,0, 64'h0};
    vecs[3]  = '{0,0,0,0,0,1, 64'hA5, 0,0,1, 0,0,0,0,1, 64'h0};
    vecs[4]  = '{0,0,0,0,1,1, 64'hB6, 0,0,1, 0,0,0,0,1, 64'hA5};
    vecs[5]  = '{0,0,0,0,1,0, 64'h0,  0,0,0, 0,0,0,0,0, 64'hB6};
    vecs[6]  = '{1,0,0,0,0,0, 64'h11, 1,0,0, 0,0,0,0,0, 64'hB6};
    vecs[7]  = '{0,1,0,0,0,0, 64'h22, 1,1,0, 0,0,0,0,0, 64'hB6};
    vecs[8]  = '{0,0,1,0,0,0, 64'h0,  1,1,0, 0,0,0,1,0, 64'hB6};
    vecs[9]  = '{1,1,0,0,0,1, 64'hC7, 2,2,1, 0,0,0,0,1, 64'hB6};
    vecs[10] = '{0,0,1,1,0,0, 64'h0,  2,2,1, 0,0,0,1,1, 64'hB6};
    vecs[11] = '{0,0,0,0,1,0, 64'h0,  2,2,0, 0,0,0,0,0, 64'hC7};
    vecs[12] = '{0,0,0,0,0,0, 64'h0,  2,2,0, 0,0,0,0,0, 64'hC7};

    reset_dut();
    chk("reset_design_busy", 64'(design_busy), 64'h0);
    chk("reset_inputs", inputs, 64'h0);
    for (int v = 0; v < 13; v++) begin
      write_weight = vecs[v].ww; write_input = vecs[v].wi;
      load_weight = vecs[v].lw; start_inference = vecs[v].si;
      output_read = vecs[v].rd; activations_valid = vecs[v].av;
      weight_data = vecs[v].d; input_data = vecs[v].d; activations = vecs[v].d;
      tick();
      clear_inputs();
      chk($sformatf("vec%0d_w_count", v), 64'(w_count), 64'(vecs[v].ew));
      chk($sformatf("vec%0d_i_count", v), 64'(i_count), 64'(vecs[v].ei));
      chk($sformatf("vec%0d_o_count", v), 64'(o_count), 64'(vecs[v].eo));
      chk($sformatf("vec%0d_err_w", v), 64'(occupancy_err_w), 64'(vecs[v].eerr_w));
      chk($sformatf("vec%0d_err_i", v), 64'(occupancy_err_i), 64'(vecs[v].eerr_i));
      chk($sformatf("vec%0d_err_o", v), 64'(occupancy_err_o), 64'(vecs[v].eerr_o));
      chk($sformatf("vec%0d_busy_err", v), 64'(device_busy_err), 64'(vecs[v].ebusy_err));
      chk($sformatf("vec%0d_data_ready", v), 64'(data_ready), 64'(vecs[v].edr));
      chk($sformatf("vec%0d_output_data", v), output_data, vecs[v].eout);
      chk($sformatf("vec%0d_design_busy", v), 64'(design_busy), 64'h0);
    end

    // Weight fill, overflow and streaming.
    reset_dut();
    for (int k = 0; k < DEPTH; k++) begin
      write_weight = 1; weight_data = 64'h1111111100001111;
      tick();
    end
    chk("wfill_count", 64'(w_count), 64'd8);
    chk("wfill_err", 64'(occupancy_err_w), 64'h0);
    tick();
    write_weight = 0;
    chk("wover_err", 64'(occupancy_err_w), 64'h1);
    chk("wover_count", 64'(w_count), 64'd8);
    tick();
    chk("wover_pulse_end", 64'(occupancy_err_w), 64'h0);
    load_weight = 1;
    tick();
    load_weight = 0;
    chk("load_accept_err", 64'(device_busy_err), 64'h0);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("load_hi_%0d", k), 64'(load), 64'h1);
      chk($sformatf("load_busy_%0d", k), 64'(design_busy), 64'h1);
      chk($sformatf("load_word_%0d", k), inputs, 64'h1111111100001111);
      chk($sformatf("load_wcount_%0d", k), 64'(w_count), 64'(DEPTH - 1 - k));
      tick();
    end
    chk("load_done", 64'(load), 64'h0);
    chk("load_done_busy", 64'(design_busy), 64'h0);
    chk("load_done_inputs", inputs, 64'h0);

    // Inference stream, collection and readback.
    push_inputs(64'hB0);
`ifndef ACCEL_BUF_AUTO_START_EN
    tick();
    chk("no_autostart", 64'(array_start), 64'h0);
    chk("no_autostart_busy", 64'(design_busy), 64'h0);
    chk("no_autostart_icount", 64'(i_count), 64'd8);
    start_inference = 1;
`endif
    tick();
    start_inference = 0;
    chk("start_no_err", 64'(device_busy_err), 64'h0);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("infer_start_%0d", k), 64'(array_start), 64'h1);
      chk($sformatf("infer_word_%0d", k), inputs, 64'hB0 + 64'(k));
      chk($sformatf("infer_icount_%0d", k), 64'(i_count), 64'(DEPTH - 1 - k));
      tick();
    end
    chk("collect_start_low", 64'(array_start), 64'h0);
    chk("collect_busy", 64'(design_busy), 64'h1);
    chk("collect_inputs", inputs, 64'h0);
    for (int k = 0; k < OUT_DEPTH; k++) begin
      activations_valid = 1; activations = 64'hA0 + 64'(k);
      tick();
    end
    activations_valid = 0;
    chk("collect_ocount", 64'(o_count), 64'd8);
    chk("collect_not_ready", 64'(data_ready), 64'h0);
    tick();
    chk("collect_ready", 64'(data_ready), 64'h1);
    chk("collect_idle", 64'(design_busy), 64'h0);
    output_read = 1;
    for (int k = 0; k < OUT_DEPTH; k++) begin
      tick();
      chk($sformatf("read_data_%0d", k), output_data, 64'hA0 + 64'(k));
      chk($sformatf("read_ocount_%0d", k), 64'(o_count), 64'(OUT_DEPTH - 1 - k));
    end
    tick();
    output_read = 0;
    chk("read_under_err", 64'(occupancy_err_o), 64'h1);
    chk("read_under_hold", output_data, 64'hA7);
    tick();
    chk("read_under_pulse_end", 64'(occupancy_err_o), 64'h0);

    // Asynchronous reset in the 4th inference cycle.
    push_inputs(64'hC0);
    start_inference = 1;
    tick();
    start_inference = 0;
    write_weight = 1; weight_data = 64'h5;
    tick(); tick(); tick();
    write_weight = 0;
    chk("mid_start", 64'(array_start), 64'h1);
    chk("mid_icount", 64'(i_count), 64'd4);
    chk("mid_wcount", 64'(w_count), 64'd3);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_wcount", 64'(w_count), 64'h0);
    chk("arst_icount", 64'(i_count), 64'h0);
    chk("arst_ocount", 64'(o_count), 64'h0);
    chk("arst_start", 64'(array_start), 64'h0);
    chk("arst_busy", 64'(design_busy), 64'h0);
    chk("arst_inputs", inputs, 64'h0);
    tick();
    n_rst = 1'b1;
    tick();
    chk("arst_after_busy", 64'(design_busy), 64'h0);
    chk("arst_after_icount", 64'(i_count), 64'h0);

    // Randomized run against the reference model.
    reset_dut();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      write_weight      = ($urandom_range(0, 99) < 40);
      write_input       = ($urandom_range(0, 99) < 40);
      load_weight       = ($urandom_range(0, 99) < 10);
      start_inference   = ($urandom_range(0, 99) < 10);
      output_read       = ($urandom_range(0, 99) < 15);
      activations_valid = ($urandom_range(0, 99) < 20);
      array_busy        = ($urandom_range(0, 99) < 10);
      weight_data = {$urandom, $urandom};
      input_data  = {$urandom, $urandom};
      activations = {$urandom, $urandom};
      model_step();
      tick();
      model_compare();
    end
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
